rv_mem_arb: RTL
===============

Name: rv_mem_arb

Overview:
Two-requester arbiter sharing one single-port, byte-enabled 32-bit RAM. Requester 0 is the rv_core data port. Requester 1 is the host/debug loader that writes program images and reads back results. Sits inside rvc between the requesters and the RAM macro, and sequences every RAM access: one grant per cycle, synchronous read data, response routed back to the owner.

Parameters:
AW, 16, word-address width of the RAM (RAM holds 2^AW 32-bit words)
MAXWAIT, 8, consecutive cycles requester 1 may be denied before it is forced to win one grant (range 1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
xreset  input  1  synchronous active-low reset, sampled on rising edge of clk
m0_req  input  1  requester 0 access request; held until granted
m0_we  input  4  byte write enables; 0 = read
m0_addr  input  AW  word address
m0_wdat  input  32  write data
m0_gnt  output  1  request 0 accepted this cycle
m0_rdat  output  32  read data
m0_rvalid  output  1  m0_rdat valid (read granted previous cycle)
m1_req, m1_we, m1_addr, m1_wdat, m1_gnt, m1_rdat, m1_rvalid  same as m0, for requester 1
mem_en  output  1  RAM enable
mem_we  output  4  RAM byte write enables
mem_addr  output  AW  RAM word address
mem_wdat  output  32  RAM write data
mem_rdat  input  32  RAM read data, valid one cycle after mem_en with mem_we == 0
starve_cnt  output  8  current denial count of requester 1 (debug)

Behaviour:
- Reset (xreset == 0 at a clock edge): starve_cnt = 0, owner register = 0, rvalid pipeline cleared, RR pointer = 0.
- Reset outputs: m0_gnt = m1_gnt = m0_rvalid = m1_rvalid = 0. m0_rdat, m1_rdat and mem_* outputs are combinational from inputs; mem_en = 0 while xreset = 0.
- Grant path is combinational in the same cycle.
  - Only one of m0_req/m1_req asserted: that requester is granted.
  - Both asserted: m0 wins unless starve_cnt == MAXWAIT, in which case m1 wins.
- mem_en = m0_gnt | m1_gnt. mem_we/addr/wdat are muxed from the granted requester. Requester inputs are ignored when not granted.
- Registered per cycle:
  - rd_owner = granting port.
  - rd_pend = granted & (we == 0).
- Read responses: next cycle, mX_rvalid = rd_pend & (rd_owner == X). m0_rdat = m1_rdat = mem_rdat, and are meaningful only with the matching rvalid.
- Write responses: no response; the write completes in the grant cycle.
- Latency: read returns exactly 1 cycle after grant. Back-to-back grants are allowed every cycle, to the same or alternating owners.
- starve_cnt:
  - Increments (saturating at 255) when m1_req = 1 and m1_gnt = 0.
  - Clears to 0 on m1_gnt or when m1_req = 0.
- Boundaries:
  - MAXWAIT = 1 gives strict alternation under continuous contention.
  - Both requests deasserted: mem_en = 0 and counters hold/clear per the rules above.
  - Reset asserted while a read is in flight: the pending rvalid is dropped.
  - A requester that drops req before grant loses nothing; there is no queued state.

Optional Feature:
RV_MEM_ARB_RR_EN
- Defined: round-robin arbitration replaces priority.
  - A 1-bit pointer indicates the preferred port; it toggles after every contended cycle.
  - Under continuous contention grants alternate 0,1,0,1, with port 0 first after reset.
  - starve_cnt is still maintained but never forces a grant.
- Undefined: fixed priority plus the MAXWAIT starvation guard described above.

Decomposition:
- Package rv_types: u32_t, u8_t, a mem_req_t struct {we[3:0], addr, wdat}, and a port-index enum {P_CORE, P_HOST}.
- Sub-module rv_arb2: the pure grant-decision logic (req pair, starve flag, RR pointer in; grant pair out), instantiated once.
- Owner/rvalid pipeline and counter live in the top block.

Test Plan:
- After reset, m0 reads addr 0x10 holding 0x12345678 (preloaded by m1 write with we = 0xF): m0_gnt same cycle; next cycle m0_rvalid = 1, m0_rdat = 0x12345678, m1_rvalid = 0.
- m0_req and m1_req held high for 20 cycles, MAXWAIT = 8: m1_gnt first at cycle 9, starve_cnt sequence 0..8 then 0; pattern repeats.
- m1 byte write we = 0b0010, wdat = 0x0000AB00 to a word holding 0xFFFFFFFF, then read: rdat = 0xFFFFABFF.
- Alternating reads m0 @0x20, m1 @0x21, m0 @0x22 on consecutive cycles: each rvalid lands on the correct port one cycle later with the correct data, and no cross-routing occurs.
- xreset pulled low the cycle after an m1 read grant: m1_rvalid stays 0, starve_cnt = 0, mem_en = 0 during reset.
- With RV_MEM_ARB_RR_EN, both requesting for 6 cycles: grants 0,1,0,1,0,1.

Source files
------------

// File: rtl/rv_mem_arb_pkg.sv
// rv_types: shared types for the rv_mem_arb RAM arbiter slice.
// Provides word/byte aliases, the request bundle muxed onto the RAM port,
// the owner enum used to route read responses, and a saturating increment.
package rv_types;

  typedef logic [31:0] u32_t;
  typedef logic [7:0]  u8_t;

  // Request address is carried at a fixed maximum width; the top sizes it
  // down to its own AW when driving the RAM.
  localparam int unsigned ADDR_MAX_W = 32;

  typedef struct packed {
    logic [3:0]            we;
    logic [ADDR_MAX_W-1:0] addr;
    u32_t                  wdat;
  } mem_req_t;

  typedef enum logic {
    P_CORE = 1'b0,
    P_HOST = 1'b1
  } port_e;

  function automatic u8_t sat_inc(input u8_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rv_mem_arb_arb2.sv
// rv_arb2: two-way grant decision, purely combinational.
// Ports: req0/req1 in, starve (priority build) or rr_ptr (round-robin build)
// in, gnt0/gnt1 out (one-hot or zero). Build option: RV_MEM_ARB_RR_EN.
module rv_arb2 (
  input  logic req0,
  input  logic req1,
`ifdef RV_MEM_ARB_RR_EN
  input  logic rr_ptr,
`else
  input  logic starve,
`endif
  output logic gnt0,
  output logic gnt1
);

  logic prefer1;

`ifdef RV_MEM_ARB_RR_EN
  // Pointer names the port that wins the next contended cycle.
  assign prefer1 = rr_ptr;
`else
  // Fixed priority to port 0 unless port 1 has waited its maximum.
  assign prefer1 = starve;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = ~prefer1;
      gnt1 = prefer1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one single-port byte-enabled 32-bit RAM between the
// core data port (m0) and the host loader (m1). Grant is combinational,
// read data returns one cycle after grant on the owner's rvalid.
// Ports: clk, xreset (sync, active low); per requester req/we/addr/wdat in,
// gnt/rdat/rvalid out; mem_en/we/addr/wdat out, mem_rdat in; starve_cnt out.
// Build option: RV_MEM_ARB_RR_EN selects round-robin instead of priority.
module rv_mem_arb
  import rv_types::*;
#(
  parameter int AW      = 16,
  parameter int MAXWAIT = 8
) (
  input  logic          clk,
  input  logic          xreset,
  input  logic          m0_req,
  input  logic [3:0]    m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wdat,
  output logic          m0_gnt,
  output logic [31:0]   m0_rdat,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [3:0]    m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wdat,
  output logic          m1_gnt,
  output logic [31:0]   m1_rdat,
  output logic          m1_rvalid,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdat,
  input  logic [31:0]   mem_rdat,
  output logic [7:0]    starve_cnt
);

  logic     req0, req1;
  logic     gnt0, gnt1;
  mem_req_t r0, r1, sel;
  port_e    rd_owner;
  logic     rd_pend;

  // No grants while reset is held, so the RAM is never enabled in reset.
  assign req0 = m0_req & xreset;
  assign req1 = m1_req & xreset;

`ifdef RV_MEM_ARB_RR_EN
  logic rr_ptr;

  rv_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (rr_ptr),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Toggle only when both competed; an uncontended grant keeps the turn.
  always_ff @(posedge clk) begin
    if (!xreset)
      rr_ptr <= 1'b0;
    else if (req0 && req1)
      rr_ptr <= ~rr_ptr;
  end
`else
  logic starve;

  assign starve = (starve_cnt == u8_t'(MAXWAIT));

  rv_arb2 u_arb (
    .req0   (req0),
    .req1   (req1),
    .starve (starve),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );
`endif

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    r0  = '{we: m0_we, addr: ADDR_MAX_W'(m0_addr), wdat: m0_wdat};
    r1  = '{we: m1_we, addr: ADDR_MAX_W'(m1_addr), wdat: m1_wdat};
    sel = gnt1 ? r1 : r0;
  end

  // Byte enables are forced low when idle so a stray we can never write.
  assign mem_en   = gnt0 | gnt1;
  assign mem_we   = mem_en ? sel.we : 4'h0;
  assign mem_addr = sel.addr[AW-1:0];
  assign mem_wdat = sel.wdat;

  always_ff @(posedge clk) begin
    if (!xreset) begin
      rd_owner   <= P_CORE;
      rd_pend    <= 1'b0;
      starve_cnt <= 8'd0;
    end else begin
      rd_pend <= mem_en & (sel.we == 4'h0);
      if (mem_en)
        rd_owner <= gnt1 ? P_HOST : P_CORE;
      if (m1_req && !gnt1)
        starve_cnt <= sat_inc(starve_cnt);
      else
        starve_cnt <= 8'd0;
    end
  end

  // Gated by xreset so a read in flight when reset arrives never reports.
  assign m0_rvalid = xreset & rd_pend & (rd_owner == P_CORE);
  assign m1_rvalid = xreset & rd_pend & (rd_owner == P_HOST);
  assign m0_rdat   = mem_rdat;
  assign m1_rdat   = mem_rdat;

endmodule
